// File: rtl/bytepack.sv
// bytepack: assembles a byte stream into WIDTH-bit words, LE or rev8 order.
// Ports: In* byte handshake (valid/ready/last/rev), Out* registered word handshake.
module bytepack #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [7:0]         InByte,
  input  logic               InLast,
  input  logic               Rev,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   OutWord,
  output logic [WIDTH/8-1:0] OutMask,
  output logic               OutZeroByte
);

  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(NB);

  logic [CW-1:0]    cnt;
  logic             rev_q;
  logic [WIDTH-1:0] acc_data;
  logic [NB-1:0]    acc_mask;
  logic             acc_zero;

  logic             in_fire;
  logic             out_fire;
  logic             first;
  logic             order;
  logic             done;
  logic [NB-1:0]    lane_sel;
  logic [WIDTH-1:0] nxt_data;
  logic [NB-1:0]    nxt_mask;
  logic             nxt_zero;

  assign InReady  = ~OutValid | OutReady;
  assign in_fire  = InValid & InReady;
  assign out_fire = OutValid & OutReady;
  assign first    = (cnt == '0);

  // Rev only matters on the first byte; later bytes follow the latched order.
  assign order = first ? Rev : rev_q;

  always_comb begin
    lane_sel = '0;
    for (int j = 0; j < NB; j++) begin
      if (order)
        lane_sel[j] = (cnt == CW'(NB - 1 - j));
      else
        lane_sel[j] = (cnt == CW'(j));
    end
  end

  always_comb begin
    nxt_data = acc_data;
    for (int j = 0; j < NB; j++) begin
      if (lane_sel[j])
        nxt_data[8*j +: 8] = InByte;
    end
    nxt_mask = acc_mask | lane_sel;
    nxt_zero = acc_zero | (InByte == 8'h00);
  end

  assign done = in_fire & ((cnt == CW'(NB - 1)) | InLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      rev_q    <= 1'b0;
      acc_data <= '0;
      acc_mask <= '0;
      acc_zero <= 1'b0;
    end else if (in_fire) begin
      if (first)
        rev_q <= Rev;
      if (done) begin
        cnt      <= '0;
        acc_data <= '0;
        acc_mask <= '0;
        acc_zero <= 1'b0;
      end else begin
        cnt      <= cnt + CW'(1);
        acc_data <= nxt_data;
        acc_mask <= nxt_mask;
        acc_zero <= nxt_zero;
      end
    end
  end

  // A completing word overrides a same-cycle drain, keeping OutValid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      OutValid    <= 1'b0;
      OutWord     <= '0;
      OutMask     <= '0;
      OutZeroByte <= 1'b0;
    end else if (done) begin
      OutValid    <= 1'b1;
      OutWord     <= nxt_data;
      OutMask     <= nxt_mask;
      OutZeroByte <= nxt_zero;
    end else if (out_fire) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bytepack.sv
// tb_bytepack: scoreboard bench for bytepack (WIDTH=32).
// Directed test-plan vectors plus randomized traffic against a byte-queue model.
module tb_bytepack;

  localparam int WIDTH = 32;
  localparam int NB    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [7:0]    InByte = 8'h00;
  logic          InLast = 1'b0;
  logic          Rev = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic [31:0]   OutWord;
  logic [3:0]    OutMask;
  logic          OutZeroByte;

  always #5 clk = ~clk;

  bytepack #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .InValid(InValid),
    .InReady(InReady),
    .InByte(InByte),
    .InLast(InLast),
    .Rev(Rev),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .OutWord(OutWord),
    .OutMask(OutMask),
    .OutZeroByte(OutZeroByte)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  m;
    logic        z;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  logic       cur_rev = 1'b0;
  exp_t       e_pop;
  exp_t       e_new;
  exp_t       held;
  bit         stall_prev = 1'b0;
  bit         rand_ready = 1'b0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor and reference model, both sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      cur.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {63'd0, OutValid}, 64'd1);
        check("stall_hold", {27'd0, OutWord, OutMask, OutZeroByte},
              {27'd0, held});
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got word %h, expected none", OutWord);
        end else begin
          e_pop = exp_q.pop_front();
          check("sb_word", {27'd0, OutWord, OutMask, OutZeroByte},
                {27'd0, e_pop});
        end
      end
      stall_prev = OutValid && !OutReady;
      held = {OutWord, OutMask, OutZeroByte};
      if (InValid && InReady) begin
        if (cur.size() == 0)
          cur_rev = Rev;
        cur.push_back(InByte);
        if (cur.size() == NB || InLast) begin
          e_new = '0;
          for (int i = 0; i < cur.size(); i++) begin
            int lane;
            lane = cur_rev ? NB - 1 - i : i;
            e_new.w[8*lane +: 8] = cur[i];
            e_new.m[lane] = 1'b1;
            if (cur[i] == 8'h00)
              e_new.z = 1'b1;
          end
          exp_q.push_back(e_new);
          cur.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready)
      OutReady = 1'($urandom_range(0, 1));
  end

  task automatic put_byte(input logic [7:0] b, input logic last,
                          input logic rv);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    InValid = 1'b1;
    InByte = b;
    InLast = last;
    Rev = rv;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = InReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL put_byte: byte %h not accepted, expected accept", b);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input int n,
                           input logic last, input logic rev0,
                           input logic revr);
    for (int i = 0; i < n; i++)
      put_byte(d[8*i +: 8], last && (i == n - 1), (i == 0) ? rev0 : revr);
    InValid = 1'b0;
    InLast = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] w,
                            input logic [3:0] m, input logic z);
    @(negedge clk);
    check({name, "_valid"}, {63'd0, OutValid}, 64'd1);
    check(name, {27'd0, OutWord, OutMask, OutZeroByte}, {27'd0, w, m, z});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string name);
    #2;
    reset_n = 1'b0;
    #1;
    check({name, "_outs"}, {27'd0, OutWord, OutMask, OutZeroByte}, 64'd0);
    check({name, "_valid"}, {63'd0, OutValid}, 64'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_inready"}, {63'd0, InReady}, 64'd1);
  endtask

  initial begin
    #1;
    check("rst_outs", {27'd0, OutWord, OutMask, OutZeroByte}, 64'd0);
    check("rst_valid", {63'd0, OutValid}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_inready", {63'd0, InReady}, 64'd1);

    send_word(32'h44332211, 4, 1'b0, 1'b0, 1'b0);
    expect_out("le_full", 32'h44332211, 4'hF, 1'b0);
    @(negedge clk);
    check("valid_one_cycle", {63'd0, OutValid}, 64'd0);
    @(posedge clk);
    #1;

    send_word(32'h44332211, 4, 1'b0, 1'b1, 1'b1);
    expect_out("rev_full", 32'h11223344, 4'hF, 1'b0);
    send_word(32'h0000BBAA, 2, 1'b1, 1'b0, 1'b0);
    expect_out("le_part", 32'h0000BBAA, 4'b0011, 1'b0);
    send_word(32'h0000BBAA, 2, 1'b1, 1'b1, 1'b1);
    expect_out("rev_part", 32'hAABB0000, 4'b1100, 1'b0);
    send_word(32'h04030201, 4, 1'b0, 1'b1, 1'b0);
    expect_out("rev_mid", 32'h01020304, 4'hF, 1'b0);
    send_word(32'h03020001, 4, 1'b0, 1'b0, 1'b0);
    expect_out("zero_det", 32'h03020001, 4'hF, 1'b1);
    send_word(32'h000000C5, 1, 1'b1, 1'b1, 1'b1);
    expect_out("single_rev", 32'hC5000000, 4'b1000, 1'b0);

    OutReady = 1'b0;
    send_word(32'h44332211, 4, 1'b0, 1'b0, 1'b0);
    InValid = 1'b1;
    InByte = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("bp_inready", {63'd0, InReady}, 64'd0);
      check("bp_word", {32'd0, OutWord}, 64'h44332211);
      @(posedge clk);
      #1;
    end
    OutReady = 1'b1;
    send_word(32'h88776655, 4, 1'b0, 1'b0, 1'b0);
    expect_out("bp_next", 32'h88776655, 4'hF, 1'b0);

    put_byte(8'hA1, 1'b0, 1'b1);
    put_byte(8'hA2, 1'b0, 1'b1);
    InValid = 1'b0;
    reset_check("rst_mid");
    send_word(32'hDDCCBBAA, 4, 1'b0, 1'b0, 1'b0);
    expect_out("after_rst_mid", 32'hDDCCBBAA, 4'hF, 1'b0);

    OutReady = 1'b0;
    send_word(32'h12345678, 4, 1'b0, 1'b0, 1'b0);
    reset_check("rst_pend");
    OutReady = 1'b1;
    send_word(32'h9ABCDEF0, 4, 1'b0, 1'b0, 1'b0);
    expect_out("after_rst_pend", 32'h9ABCDEF0, 4'hF, 1'b0);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        InValid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        logic [7:0] b;
        b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        put_byte(b, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      end
    end
    put_byte(8'hEE, 1'b1, 1'b0);
    InValid = 1'b0;
    InLast = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    OutReady = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_partial", 64'(cur.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, expected finish");
    $fatal(1);
  end

endmodule
